// File: rtl/wave_gen_pkg.sv
// Shared encodings, FSM state type and mode-decode helper for the wave_gen
// periodic waveform generator.
package wave_gen_pkg;

    localparam logic [1:0] MODE_TRI = 2'd0;
    localparam logic [1:0] MODE_SAW = 2'd1;
    localparam logic [1:0] MODE_SQR = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } state_e;

    typedef struct packed {
        logic saw;
        logic sqr;
    } mode_dec_t;

    // The reserved encoding falls through to triangle behaviour.
    function automatic mode_dec_t decode_mode(input logic [1:0] mode);
        mode_dec_t dec;
        dec.saw = (mode == MODE_SAW);
        dec.sqr = (mode == MODE_SQR);
        return dec;
    endfunction

endpackage

// File: rtl/wave_gen_if.sv
// Configuration handshake and sample stream of wave_gen; master is the
// controller side, slave is the generator.
interface wave_gen_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned PRESC_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_mode;
    logic [WIDTH-1:0]   cfg_amplitude;
    logic [WIDTH-1:0]   cfg_step;
    logic [PRESC_W-1:0] cfg_prescaler;
    logic [WIDTH-1:0]   data;
    logic               data_valid;
    logic               period_end;

    modport master (
        output cfg_valid, cfg_mode, cfg_amplitude, cfg_step, cfg_prescaler,
        input  cfg_ready, data, data_valid, period_end
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_amplitude, cfg_step, cfg_prescaler,
        output cfg_ready, data, data_valid, period_end
    );
endinterface

// File: rtl/wave_prescaler.sv
// Tick prescaler: counts 0..presc_i while running and pulses tick_o on the
// count that matches presc_i; held at zero whenever run_i is low.
module wave_prescaler #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);
    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == presc_i);

    always_comb begin
        cnt_d = cnt_q + PRESC_W'(1);
        if (!run_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wave_gen.sv
// Periodic triangle/sawtooth/square generator. A handshaked shadow config is
// copied to the active config only while idle or on a period_end edge.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned PRESC_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ena,
    wave_gen_if.slave bus
);
    typedef struct packed {
        logic [1:0]         mode;
        logic [WIDTH-1:0]   amp;
        logic [WIDTH-1:0]   step;
        logic [PRESC_W-1:0] presc;
    } cfg_t;

    localparam cfg_t CfgReset = '{mode: MODE_TRI, amp: '1, step: WIDTH'(1), presc: '0};

    cfg_t             act_q, shd_q;
    logic             pend_q;
    state_e           state_q;
    logic [WIDTH-1:0] ph_q, data_q;
    logic             dv_q, pe_q;

    mode_dec_t        dec;
    logic             run, tick, accept, copy, wrap;
    logic [WIDTH-1:0] step_eff, ph_nxt, sample;
    logic [WIDTH:0]   sum;
    state_e           state_nxt;

    wave_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_i   (run),
        .presc_i (act_q.presc),
        .tick_o  (tick)
    );

    assign dec    = decode_mode(act_q.mode);
    assign run    = ena && (state_q != StIdle);
    assign accept = bus.cfg_valid && !pend_q;
    assign copy   = pend_q && ((state_q == StIdle) || (tick && wrap));

    // Ramp step evaluated for the current state; only committed on a tick.
    always_comb begin
        step_eff  = (act_q.step == '0) ? WIDTH'(1) : act_q.step;
        sum       = {1'b0, ph_q} + {1'b0, step_eff};
        ph_nxt    = ph_q;
        state_nxt = state_q;
        wrap      = 1'b0;
        if (act_q.amp == '0) begin
            ph_nxt    = '0;
            state_nxt = StUp;
            wrap      = 1'b1;
        end else if (state_q == StUp) begin
            if (sum >= {1'b0, act_q.amp}) begin
                ph_nxt    = act_q.amp;
                state_nxt = StDown;
            end else begin
                ph_nxt = sum[WIDTH-1:0];
            end
        end else if (dec.saw || (ph_q <= step_eff)) begin
            ph_nxt    = '0;
            state_nxt = StUp;
            wrap      = 1'b1;
        end else begin
            ph_nxt = ph_q - step_eff;
        end
    end

    // Square output follows the direction the tick was taken in, not the next one.
    always_comb begin
        sample = ph_nxt;
        if (dec.sqr) begin
            sample = (state_q == StUp) ? act_q.amp : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= CfgReset;
            shd_q   <= CfgReset;
            pend_q  <= 1'b0;
            state_q <= StIdle;
            ph_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;

            // accept needs pend low and copy needs pend high, so they never coincide.
            if (accept) begin
                shd_q  <= '{mode: bus.cfg_mode, amp: bus.cfg_amplitude,
                            step: bus.cfg_step, presc: bus.cfg_prescaler};
                pend_q <= 1'b1;
            end else if (copy) begin
                act_q  <= shd_q;
                pend_q <= 1'b0;
            end

            if (!ena) begin
                state_q <= StIdle;
                ph_q    <= '0;
                data_q  <= '0;
            end else if (state_q == StIdle) begin
                state_q <= StUp;
            end else if (tick) begin
                state_q <= state_nxt;
                ph_q    <= ph_nxt;
                data_q  <= sample;
                dv_q    <= 1'b1;
                pe_q    <= wrap;
            end
        end
    end

    assign bus.cfg_ready  = !pend_q;
    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.period_end = pe_q;
endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: table vectors, randomized configs against a
// period model, and hand-written config/ena/reset sequences.
module tb_wave_gen;
    logic clk;
    logic rst_n;
    logic ena;

    wave_gen_if #(.WIDTH(16), .PRESC_W(16)) bus ();

    wave_gen #(
        .WIDTH   (16),
        .PRESC_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit pe;
    } samp_t;

    typedef struct {
        logic [1:0]       mode;
        int               amp;
        int               step;
        int               presc;
        logic [0:7][15:0] smp;
        logic [0:7]       pe;
    } vec_t;

    samp_t exp_q[$];
    vec_t  vecs[8];
    int    n_checks;
    int    n_fail;
    int    seq_a[24] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                         1, 2, 3, 0, 1, 2, 1, 0};

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endfunction

    // One period as a list of samples: ramp up min(k*s, amp), then either a drop to 0
    // (sawtooth) or amp - j*s down to 0 (triangle/square).
    function automatic void model_period(input int mode, input int amp, input int step);
        int s;
        int n_up;
        s = (step == 0) ? 1 : step;
        exp_q.delete();
        if (amp == 0) begin
            exp_q.push_back('{0, 1'b1});
            return;
        end
        n_up = (amp + s - 1) / s;
        for (int k = 1; k <= n_up; k++) begin
            exp_q.push_back('{(mode == 2) ? amp : ((k * s < amp) ? k * s : amp), 1'b0});
        end
        if (mode != 1) begin
            for (int j = 1; amp - j * s > 0; j++) begin
                exp_q.push_back('{(mode == 2) ? 0 : amp - j * s, 1'b0});
            end
        end
        exp_q.push_back('{0, 1'b1});
    endfunction

    task automatic send_cfg();
        int n = 0;
        bus.cfg_valid = 1'b1;
        while (!bus.cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cfg_ready_wait", 32'(n < 100), 32'd1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("cfg_accept", 32'(bus.cfg_ready), 32'd0);
    endtask

    task automatic load_cfg(input logic [1:0] mode, input int amp, input int step,
                            input int presc);
        bus.cfg_mode      = mode;
        bus.cfg_amplitude = 16'(amp);
        bus.cfg_step      = 16'(step);
        bus.cfg_prescaler = 16'(presc);
        send_cfg();
        @(negedge clk);
    endtask

    // Raise ena, check tick timing and samples against exp_q (cyclic), then drop ena.
    task automatic run_check(input string name, input int presc, input int nticks);
        int m = 0;
        samp_t e;
        ena = 1'b1;
        @(negedge clk);
        check({name, "_first_edge_dv"}, 32'(bus.data_valid), 32'd0);
        for (int k = 1; k <= (presc + 1) * nticks; k++) begin
            @(negedge clk);
            if (k % (presc + 1) == 0) begin
                e = exp_q[m % exp_q.size()];
                check($sformatf("%s_dv_t%0d", name, m), 32'(bus.data_valid), 32'd1);
                check($sformatf("%s_data_t%0d", name, m), 32'(bus.data), 32'(e.val));
                check($sformatf("%s_pe_t%0d", name, m), 32'(bus.period_end), 32'(e.pe));
                m++;
            end else begin
                check($sformatf("%s_nodv_c%0d", name, k),
                      32'({bus.data_valid, bus.period_end}), 32'd0);
            end
        end
        ena = 1'b0;
        @(negedge clk);
        check({name, "_idle_data"}, 32'(bus.data), 32'd0);
        check({name, "_idle_pulses"}, 32'({bus.data_valid, bus.period_end}), 32'd0);
    endtask

    initial begin
        int mode_r;
        int amp_r;
        int step_r;
        int presc_r;

        n_checks          = 0;
        n_fail            = 0;
        ena               = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_mode      = 2'd0;
        bus.cfg_amplitude = '0;
        bus.cfg_step      = '0;
        bus.cfg_prescaler = '0;
        rst_n             = 1'b1;

        vecs[0] = '{mode: 2'd0, amp: 4, step: 1, presc: 0,
                    smp: {16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0},
                    pe: 8'b0000_0001};
        vecs[1] = '{mode: 2'd1, amp: 10, step: 4, presc: 2,
                    smp: {16'd4, 16'd8, 16'd10, 16'd0, 16'd4, 16'd8, 16'd10, 16'd0},
                    pe: 8'b0001_0001};
        vecs[2] = '{mode: 2'd2, amp: 255, step: 128, presc: 0,
                    smp: {16'hFF, 16'hFF, 16'h0, 16'h0, 16'hFF, 16'hFF, 16'h0, 16'h0},
                    pe: 8'b0001_0001};
        vecs[3] = '{mode: 2'd0, amp: 3, step: 0, presc: 1,
                    smp: {16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2},
                    pe: 8'b0000_0100};
        vecs[4] = '{mode: 2'd0, amp: 0, step: 2, presc: 1,
                    smp: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    pe: 8'b1111_1111};
        vecs[5] = '{mode: 2'd3, amp: 5, step: 2, presc: 3,
                    smp: {16'd2, 16'd4, 16'd5, 16'd3, 16'd1, 16'd0, 16'd2, 16'd4},
                    pe: 8'b0000_0100};
        vecs[6] = '{mode: 2'd0, amp: 65535, step: 32768, presc: 0,
                    smp: {16'h8000, 16'hFFFF, 16'h7FFF, 16'h0,
                          16'h8000, 16'hFFFF, 16'h7FFF, 16'h0},
                    pe: 8'b0001_0001};
        vecs[7] = '{mode: 2'd1, amp: 1, step: 0, presc: 0,
                    smp: {16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0},
                    pe: 8'b0101_0101};

        #2 rst_n = 1'b0;
        #2;
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_pulses", 32'({bus.data_valid, bus.period_end}), 32'd0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_data", 32'(bus.data), 32'd0);

        for (int i = 0; i < 8; i++) begin
            load_cfg(vecs[i].mode, vecs[i].amp, vecs[i].step, vecs[i].presc);
            exp_q.delete();
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back('{int'(vecs[i].smp[j]), bit'(vecs[i].pe[j])});
            end
            run_check($sformatf("vec%0d", i), vecs[i].presc, 8);
        end

        for (int t = 0; t < 25; t++) begin
            mode_r  = $urandom_range(0, 3);
            amp_r   = $urandom_range(0, 40);
            step_r  = $urandom_range(0, 9);
            presc_r = $urandom_range(0, 3);
            load_cfg(2'(mode_r), amp_r, step_r, presc_r);
            model_period(mode_r, amp_r, step_r);
            run_check($sformatf("rnd%0d", t), presc_r, exp_q.size() + 3);
        end

        // Mid-period reconfiguration with a second offer stalled behind the first.
        load_cfg(2'd0, 8, 1, 0);
        ena = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check($sformatf("midcfg_data_k%0d", k), 32'(bus.data), 32'(seq_a[k-1]));
            check($sformatf("midcfg_dv_k%0d", k), 32'(bus.data_valid), 32'd1);
            check($sformatf("midcfg_pe_k%0d", k), 32'(bus.period_end),
                  32'(k == 16 || k == 20 || k == 24));
            check($sformatf("midcfg_ready_k%0d", k), 32'(bus.cfg_ready),
                  32'(!((k >= 3 && k <= 15) || (k >= 17 && k <= 19))));
            if (k == 2) begin
                bus.cfg_mode      = 2'd1;
                bus.cfg_amplitude = 16'd3;
                bus.cfg_step      = 16'd1;
                bus.cfg_prescaler = 16'd0;
                bus.cfg_valid     = 1'b1;
            end else if (k == 3) begin
                bus.cfg_mode      = 2'd0;
                bus.cfg_amplitude = 16'd2;
            end else if (k == 17) begin
                bus.cfg_valid = 1'b0;
            end
        end
        ena = 1'b0;
        @(negedge clk);

        // ena drop on a tick edge mid-ramp.
        load_cfg(2'd0, 8, 1, 0);
        ena = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("enadrop_before", 32'(bus.data), 32'd3);
        ena = 1'b0;
        @(negedge clk);
        check("enadrop_data", 32'(bus.data), 32'd0);
        check("enadrop_pulses", 32'({bus.data_valid, bus.period_end}), 32'd0);
        @(negedge clk);
        check("enadrop_hold", 32'({bus.data, bus.data_valid, bus.period_end}), 32'd0);

        // Asynchronous reset mid-ramp with a pending config that must be discarded.
        load_cfg(2'd0, 8, 1, 0);
        ena = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("rstmid_before", 32'(bus.data), 32'd4);
        bus.cfg_mode      = 2'd1;
        bus.cfg_amplitude = 16'd20;
        bus.cfg_step      = 16'd5;
        bus.cfg_prescaler = 16'd0;
        bus.cfg_valid     = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("rstmid_pending", 32'(bus.cfg_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_async_data", 32'(bus.data), 32'd0);
        check("rstmid_async_ready", 32'(bus.cfg_ready), 32'd1);
        check("rstmid_async_dv", 32'(bus.data_valid), 32'd0);
        ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int v = 1; v <= 5; v++) begin
            exp_q.push_back('{v, 1'b0});
        end
        run_check("post_reset", 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
